// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: constants shared by the RV32I fetch front end.
// Holds the fetch FSM encoding, the NOP encoding used for IF/ID bubbles,
// the default reset/trap vectors and a target alignment helper.
package rv_pipe_pkg;

  localparam logic [1:0] FETCH_ST_BOOT  = 2'd0;
  localparam logic [1:0] FETCH_ST_FETCH = 2'd1;
  localparam logic [1:0] FETCH_ST_HOLD  = 2'd2;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

  // Instruction fetch targets must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// fetch_redirect_sel: priority select of the fetch target.
// Priority is trap > EX redirect > pending (latched during a wait state),
// with pc+4 as the sequential fall-through.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect or pending
// target is replaced by TRAP_VEC.
module fetch_redirect_sel import rv_pipe_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEFAULT_TRAP_VEC)
) (
  input  logic            trap_valid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            pend_valid,
  input  logic [XLEN-1:0] pend_target,
  input  logic [XLEN-1:0] pc_in,
  output logic            ext_valid,
  output logic [XLEN-1:0] ext_target,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_target,
  output logic [XLEN-1:0] seq_pc
);

  logic [XLEN-1:0] redirect_eff;
  logic [XLEN-1:0] pend_eff;

  // Alignment filter on the non-trap targets.
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_eff = is_misaligned(redirect_target[1:0]) ? TRAP_VEC : redirect_target;
    pend_eff     = is_misaligned(pend_target[1:0])     ? TRAP_VEC : pend_target;
`else
    redirect_eff = redirect_target;
    pend_eff     = pend_target;
`endif
  end

  // Fresh requests this cycle (trap drops a simultaneous redirect), then
  // the full winner including the pending target.
  always_comb begin
    ext_valid    = trap_valid | redirect_valid;
    ext_target   = trap_valid ? TRAP_VEC : redirect_eff;
    redir_valid  = ext_valid | pend_valid;
    redir_target = ext_valid ? ext_target : pend_eff;
    seq_pc       = pc_in + XLEN'(4);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer for the 5-stage RV32I pipeline.
// Drives the PC register (next_pc/pc_stall), the instruction memory request
// and the IF/ID write/flush controls. All outputs are combinational.
// Optional macro FETCH_MISALIGN_TRAP_EN (see fetch_redirect_sel).
//
// state | meaning
// BOOT  | one cycle after reset release, loads RESET_VEC into the PC
// FETCH | request outstanding at pc_in, waits for imem_ready
// HOLD  | load-use stall, no request, IF/ID held
module fetch_ctrl import rv_pipe_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEFAULT_TRAP_VEC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            hazard_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  output logic            if_id_write,
  output logic            if_id_flush
);

  logic [1:0]      state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_trap_q, pend_trap_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  logic            ext_valid;
  logic [XLEN-1:0] ext_target;
  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] seq_pc;

  fetch_redirect_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_sel (
    .trap_valid      (trap_valid),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pend_valid      (pend_valid_q),
    .pend_target     (pend_target_q),
    .pc_in           (pc_in),
    .ext_valid       (ext_valid),
    .ext_target      (ext_target),
    .redir_valid     (redir_valid),
    .redir_target    (redir_target),
    .seq_pc          (seq_pc)
  );

  // Next-state and output decode. While reset is asserted the outputs are
  // forced to their reset values regardless of the registered state.
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_trap_d   = pend_trap_q;
    pend_target_d = pend_target_q;
    next_pc       = pc_in;
    pc_stall      = 1'b1;
    imem_req      = 1'b0;
    imem_addr     = pc_in;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;

    if (!reset) begin
      next_pc     = RESET_VEC;
      if_id_flush = 1'b1;
    end else begin
      case (state_q)
        FETCH_ST_BOOT: begin
          next_pc     = RESET_VEC;
          pc_stall    = 1'b0;
          if_id_flush = 1'b1;
          state_d     = FETCH_ST_FETCH;
        end
        FETCH_ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            if (redir_valid) begin
              // Returning instruction is on the wrong path: squash it.
              next_pc      = redir_target;
              pc_stall     = 1'b0;
              if_id_flush  = 1'b1;
              pend_valid_d = 1'b0;
              pend_trap_d  = 1'b0;
            end else if (hazard_stall) begin
              state_d = FETCH_ST_HOLD;
            end else begin
              next_pc     = seq_pc;
              pc_stall    = 1'b0;
              if_id_write = 1'b1;
            end
          end else begin
            if_id_flush = 1'b1;
            // A pending trap is never displaced by a later redirect.
            if (trap_valid || (redirect_valid && !(pend_valid_q && pend_trap_q))) begin
              pend_valid_d  = 1'b1;
              pend_trap_d   = trap_valid;
              pend_target_d = ext_target;
            end
          end
        end
        FETCH_ST_HOLD: begin
          // EX is older than the load-use stall, so a redirect wins.
          if (ext_valid) begin
            next_pc     = ext_target;
            pc_stall    = 1'b0;
            if_id_flush = 1'b1;
            state_d     = FETCH_ST_FETCH;
          end else if (!hazard_stall) begin
            state_d = FETCH_ST_FETCH;
          end
        end
        default: begin
          state_d = FETCH_ST_BOOT;
        end
      endcase
    end
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH_ST_BOOT;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_trap_q   <= pend_trap_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table plus randomized run against a
// behavioural model of the fetch sequencer. The bench owns the PC register.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] TRP_VEC = 32'h0000_0100;
  localparam logic [31:0] PC_RST  = 32'h0000_0FF0;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_TGT = 32'h0000_0100;
`else
  localparam logic [31:0] MIS_TGT = 32'h0000_0202;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        if_id_write;
  logic        if_id_flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk             (clk),
    .reset           (rst_b),
    .pc_in           (pc_q),
    .next_pc         (next_pc),
    .pc_stall        (pc_stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .hazard_stall    (hazard_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush)
  );

  // PC register driven by the DUT.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) pc_q <= PC_RST;
    else if (!pc_stall) pc_q <= next_pc;
  end

  typedef struct {
    logic        rst_b, rdy, haz, rv, tv;
    logic [31:0] rt;
  } stim_t;

  typedef struct {
    logic [31:0] npc;
    logic        stall, req, wr, fl;
    logic [31:0] addr;
  } outs_t;

  typedef struct {
    stim_t s;
    outs_t e;
  } vec_t;

  function automatic vec_t mk(logic r, logic rd, logic hz, logic rv, logic [31:0] rt, logic tv,
                              logic [31:0] npc, logic st, logic rq, logic [31:0] ad,
                              logic wr, logic fl);
    vec_t v;
    v.s = '{rst_b: r, rdy: rd, haz: hz, rv: rv, tv: tv, rt: rt};
    v.e = '{npc: npc, stall: st, req: rq, wr: wr, fl: fl, addr: ad};
    return v;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s got=%h want=%h t=%0t", tag, fld, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst_b           = s.rst_b;
    imem_ready      = s.rdy;
    hazard_stall    = s.haz;
    redirect_valid  = s.rv;
    redirect_target = s.rt;
    trap_valid      = s.tv;
    #1;
  endtask

  // next_pc is only meaningful when the PC register loads it, or in reset.
  task automatic cmp(input string tag, input outs_t e, input logic in_reset);
    chk(tag, "pc_stall", {31'd0, pc_stall}, {31'd0, e.stall});
    chk(tag, "imem_req", {31'd0, imem_req}, {31'd0, e.req});
    chk(tag, "imem_addr", imem_addr, e.addr);
    chk(tag, "if_id_write", {31'd0, if_id_write}, {31'd0, e.wr});
    chk(tag, "if_id_flush", {31'd0, if_id_flush}, {31'd0, e.fl});
    if (in_reset || !e.stall) chk(tag, "next_pc", next_pc, e.npc);
  endtask

  // ---------------- behavioural model ----------------
  localparam int MD_BOOT = 10, MD_RUN = 20, MD_HOLD = 30;
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_pend, m_pend_trap;
  logic [31:0] m_pend_tgt;

  function automatic logic [31:0] fix_tgt(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return (t % 4 != 0) ? TRP_VEC : t;
`else
    return t;
`endif
  endfunction

  function automatic void winner(input stim_t s, output logic w, output logic [31:0] t);
    w = 1'b1;
    if (s.tv)        t = TRP_VEC;
    else if (s.rv)   t = fix_tgt(s.rt);
    else if (m_pend) t = fix_tgt(m_pend_tgt);
    else begin w = 1'b0; t = 32'd0; end
  endfunction

  function automatic outs_t model_eval(input stim_t s);
    outs_t       e;
    logic        w;
    logic [31:0] t;
    winner(s, w, t);
    e = '{npc: 32'd0, stall: 1'b1, req: 1'b0, wr: 1'b0, fl: 1'b0, addr: m_pc};
    if (!s.rst_b) begin
      e.npc = RST_VEC; e.fl = 1'b1; e.addr = PC_RST;
    end else if (m_mode == MD_BOOT) begin
      e.npc = RST_VEC; e.stall = 1'b0; e.fl = 1'b1;
    end else if (m_mode == MD_RUN) begin
      e.req = 1'b1;
      if (!s.rdy)      e.fl = 1'b1;
      else if (w)      begin e.npc = t; e.stall = 1'b0; e.fl = 1'b1; end
      else if (!s.haz) begin e.npc = m_pc + 32'd4; e.stall = 1'b0; e.wr = 1'b1; end
    end else if (s.tv || s.rv) begin
      e.npc = t; e.stall = 1'b0; e.fl = 1'b1;
    end
    return e;
  endfunction

  function automatic void model_step(input stim_t s, input outs_t e);
    logic        w;
    logic [31:0] t;
    winner(s, w, t);
    if (!s.rst_b) begin
      m_mode = MD_BOOT; m_pend = 1'b0; m_pend_trap = 1'b0; m_pc = PC_RST;
      return;
    end
    if (!e.stall) m_pc = e.npc;
    if (m_mode == MD_BOOT) m_mode = MD_RUN;
    else if (m_mode == MD_RUN) begin
      if (s.rdy) begin
        if (w) m_pend = 1'b0;
        else if (s.haz) m_mode = MD_HOLD;
      end else if (s.tv) begin
        m_pend = 1'b1; m_pend_trap = 1'b1; m_pend_tgt = TRP_VEC;
      end else if (s.rv && !(m_pend && m_pend_trap)) begin
        m_pend = 1'b1; m_pend_trap = 1'b0; m_pend_tgt = s.rt;
      end
    end else if (s.tv || s.rv || !s.haz) m_mode = MD_RUN;
  endfunction

  initial begin
    vec_t  vecs[$];
    stim_t s;
    outs_t e;

    rst_b = 1'b1; imem_ready = 1'b0; hazard_stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'd0; trap_valid = 1'b0;
    #2 rst_b = 1'b0;

    //                r  rdy haz rv  rt            tv   npc           st rq addr          wr fl
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, PC_RST,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, PC_RST,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h4,        0, 1, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h8,        0, 1, 32'h4,        1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'hC,        0, 1, 32'h8,        1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h10,       0, 1, 32'hC,        1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h10,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h14,       0, 1, 32'h10,       1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h18,       0, 1, 32'h14,       1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h1C,       0, 1, 32'h18,       1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h20,       0, 1, 32'h1C,       1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h80,       0, 32'h0,        1, 1, 32'h20,       0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h20,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h80,       0, 1, 32'h20,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h84,       0, 1, 32'h80,       1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h40,       0, 32'h40,       0, 1, 32'h84,       0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h40,       0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h40,       0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h40,       0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h44,       0, 1, 32'h40,       1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h48,       0, 1, 32'h44,       1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h200,      1, 32'h100,      0, 1, 32'h48,       0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 32'h202,      0, MIS_TGT,      0, 1, 32'h100,      0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 1, MIS_TGT,      0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hFFFFFFFC, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h300,      0, 32'h0,        1, 1, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, PC_RST,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, PC_RST,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h4,        0, 1, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h4,        0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h60,       0, 32'h60,       0, 0, 32'h4,        0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h64,       0, 1, 32'h60,       1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h64,       0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 32'h500,      0, 32'h0,        1, 1, 32'h64,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h100,      0, 1, 32'h64,       0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h104,      0, 1, 32'h100,      1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].s);
      cmp($sformatf("vec%0d", i), vecs[i].e, !vecs[i].s.rst_b);
    end

    // Randomized run against the model, starting from a reset cycle.
    m_mode = MD_BOOT; m_pend = 1'b0; m_pend_trap = 1'b0; m_pend_tgt = 32'd0; m_pc = PC_RST;
    for (int c = 0; c < 2000; c++) begin
      s.rst_b = (c == 0) ? 1'b0 : logic'(($urandom % 100) != 0);
      s.rdy   = logic'(($urandom % 4) != 0);
      s.haz   = logic'(($urandom % 5) == 0);
      s.rv    = logic'(($urandom % 8) == 0);
      s.tv    = logic'(($urandom % 20) == 0);
      s.rt    = $urandom;
      if (($urandom % 4) != 0) s.rt[1:0] = 2'b00;
      drive(s);
      e = model_eval(s);
      cmp($sformatf("rnd%0d", c), e, !s.rst_b);
      model_step(s, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
